branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/batage_pkg.sv | 36 +++
 rtl/branch_resolve_unit_if.sv | 24 ++
 rtl/brq_update_fifo.sv | 68 ++++++
 rtl/branch_resolve_unit.sv | 109 ++++++++++
 tb/tb_branch_resolve_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/batage_pkg.sv
// Shared types for the branch resolve unit: the funct3 encodings, the
// predictor-update entry, and the branch outcome function.
package batage_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        mispred;
    } upd_entry_t;

    // Actual direction from the comparator flags; 010/011 never branch.
    function automatic logic resolve_taken(input logic [2:0] funct3,
                                           input logic       br_eq,
                                           input logic       br_lt);
        logic t;
        t = 1'b0;
        case (br_funct3_e'(funct3))
            F3_BEQ:           t = br_eq;
            F3_BNE:           t = !br_eq;
            F3_BLT,  F3_BLTU: t = br_lt;
            F3_BGE,  F3_BGEU: t = !br_lt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Predictor-update channel: valid/ready handshake plus the head entry fields.
interface branch_resolve_unit_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_mispred;

    modport master (
        output upd_valid,
        output upd_pc,
        output upd_taken,
        output upd_mispred,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_pc,
        input  upd_taken,
        input  upd_mispred,
        output upd_ready
    );
endinterface

// File: rtl/brq_update_fifo.sv
// Small FIFO holding resolved-branch updates until the predictor takes them.
// When full, a push is still accepted if a pop happens in the same cycle.
module brq_update_fifo
    import batage_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  upd_entry_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output upd_entry_t out_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    upd_entry_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic            full;
    logic            push;
    logic            pop;

    // Handshake and next-state computation.
    always_comb begin
        full      = (count_q == FULL_CNT);
        out_valid = (count_q != '0);
        in_ready  = !full || out_ready;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = mem_q[rd_ptr_q];

        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage conditional branches: computes the actual direction,
// issues a one-cycle fetch redirect on mispredict, queues predictor updates
// and counts resolved / mispredicted branches.
module branch_resolve_unit
    import batage_pkg::*;
#(
    parameter int unsigned UPD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_is_branch,
    input  logic [2:0]            ex_funct3,
    input  logic                  ex_BrEq,
    input  logic                  ex_BrLT,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_target,
    output logic                  br_un,
    output logic                  stall,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    branch_resolve_unit_if.master upd,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispred_cnt
);

    logic        ex_branch;
    logic        taken;
    logic        mispred;
    logic        accept;
    logic        fifo_in_ready;
    logic        fifo_out_valid;
    upd_entry_t  fifo_in_data;
    upd_entry_t  fifo_out_data;

    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q,    redirect_pc_d;
    logic [31:0] branch_cnt_q,     branch_cnt_d;
    logic [31:0] mispred_cnt_q,    mispred_cnt_d;

    // Outcome, acceptance and next-state values for this EX cycle.
    always_comb begin
        br_un            = ex_funct3[1];
        ex_branch        = ex_valid && ex_is_branch;
        taken            = resolve_taken(ex_funct3, ex_BrEq, ex_BrLT);
        mispred          = taken ^ ex_pred_taken;
        stall            = ex_branch && !fifo_in_ready;
        accept           = ex_branch && fifo_in_ready && !rst;
        fifo_in_data     = '{pc: ex_pc, taken: taken, mispred: mispred};

        redirect_valid_d = accept && mispred;
        redirect_pc_d    = taken ? ex_target : ex_pc + 32'd4;
        branch_cnt_d     = branch_cnt_q + 32'd1;
        mispred_cnt_d    = mispred_cnt_q + 32'd1;
    end

    // Redirect pulse lasts exactly one cycle; its PC holds until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            if (redirect_valid_d) begin
                redirect_pc_q <= redirect_pc_d;
            end
        end
    end

    // Wrapping event counters, advanced only on accepted branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (accept) begin
                branch_cnt_q <= branch_cnt_d;
            end
            if (accept && mispred) begin
                mispred_cnt_q <= mispred_cnt_d;
            end
        end
    end

    brq_update_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_ready  (fifo_in_ready),
        .in_data   (fifo_in_data),
        .out_valid (fifo_out_valid),
        .out_ready (upd.upd_ready),
        .out_data  (fifo_out_data)
    );

    assign upd.upd_valid   = fifo_out_valid;
    assign upd.upd_pc      = fifo_out_data.pc;
    assign upd.upd_taken   = fifo_out_data.taken;
    assign upd.upd_mispred = fifo_out_data.mispred;

    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign branch_cnt      = branch_cnt_q;
    assign mispred_cnt     = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the driver pushes expected
// redirects and updates, a negedge monitor checks them as the DUT shows them.
module tb_branch_resolve_unit;
    import batage_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic        ex_BrEq = 1'b0;
    logic        ex_BrLT = 1'b0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_target = '0;
    logic        br_un;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_resolve_unit_if upd_if ();

    branch_resolve_unit #(
        .UPD_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_funct3      (ex_funct3),
        .ex_BrEq        (ex_BrEq),
        .ex_BrLT        (ex_BrLT),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .br_un          (br_un),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd            (upd_if),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int unsigned due;
    } redir_exp_t;

    typedef struct {
        upd_entry_t  e;
        int unsigned vis;
    } upd_exp_t;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    logic        mon_en = 1'b0;
    redir_exp_t  exp_redir[$];
    upd_exp_t    exp_upd[$];
    logic [31:0] exp_br = '0;
    logic [31:0] exp_mp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT-presented redirects/updates against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            logic rv_exp;
            logic uv_exp;
            rv_exp = (exp_redir.size() != 0) && (exp_redir[0].due == cyc);
            check1("redirect_valid", redirect_valid, rv_exp);
            if (rv_exp) begin
                check32("redirect_pc", redirect_pc, exp_redir[0].pc);
                void'(exp_redir.pop_front());
            end
            uv_exp = (exp_upd.size() != 0) && (exp_upd[0].vis <= cyc);
            check1("upd_valid", upd_if.upd_valid, uv_exp);
            if (uv_exp) begin
                check32("upd_pc",   upd_if.upd_pc,           exp_upd[0].e.pc);
                check1("upd_taken",   upd_if.upd_taken,   exp_upd[0].e.taken);
                check1("upd_mispred", upd_if.upd_mispred, exp_upd[0].e.mispred);
                if (upd_if.upd_ready) begin
                    void'(exp_upd.pop_front());
                end
            end
        end
    end

    // Present one branch for a cycle; expected outcome is hand-supplied.
    task automatic drive_br(input logic [2:0] f3, input logic eq, input logic lt,
                            input logic pred, input logic [31:0] pc, input logic [31:0] tgt,
                            input logic exp_taken, input logic release_stall);
        logic exp_stall;
        logic mp;
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_funct3     = f3;
        ex_BrEq       = eq;
        ex_BrLT       = lt;
        ex_pred_taken = pred;
        ex_pc         = pc;
        ex_target     = tgt;
        #1;
        check1("br_un", br_un, f3[1]);
        exp_stall = (exp_upd.size() == DEPTH) && !upd_if.upd_ready;
        check1("stall", stall, exp_stall);
        if (exp_stall && release_stall) begin
            upd_if.upd_ready = 1'b1;
            #1;
            check1("stall_release", stall, 1'b0);
            exp_stall = 1'b0;
        end
        if (!exp_stall) begin
            mp = exp_taken ^ pred;
            exp_upd.push_back('{e: '{pc: pc, taken: exp_taken, mispred: mp}, vis: cyc + 1});
            exp_br = exp_br + 32'd1;
            if (mp) begin
                exp_mp = exp_mp + 32'd1;
                exp_redir.push_back('{pc: (exp_taken ? tgt : pc + 32'd4), due: cyc + 1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt();
        check32("branch_cnt",  branch_cnt,  exp_br);
        check32("mispred_cnt", mispred_cnt, exp_mp);
    endtask

    initial begin
        upd_if.upd_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check1("rst_redirect_valid", redirect_valid, 1'b0);
        check32("rst_redirect_pc", redirect_pc, 32'h0);
        check1("rst_upd_valid", upd_if.upd_valid, 1'b0);
        check_cnt();
        mon_en = 1'b1;

        // BGEU with BrLT=1: not taken, predicted taken -> redirect pc+4.
        drive_br(3'b111, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0280, 1'b0, 1'b0);
        check_cnt();
        // BEQ taken, predicted not taken -> redirect to target.
        drive_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0140, 1'b1, 1'b0);
        // Mixed types, back-to-back redirects, and pc+4 wrap.
        drive_br(3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0380, 1'b1, 1'b0);
        drive_br(3'b100, 1'b0, 1'b1, 1'b1, 32'h0000_0304, 32'h0000_0390, 1'b1, 1'b0);
        drive_br(3'b110, 1'b0, 1'b0, 1'b1, 32'h0000_0308, 32'h0000_0400, 1'b0, 1'b0);
        drive_br(3'b101, 1'b0, 1'b0, 1'b0, 32'h0000_030C, 32'h0000_0500, 1'b1, 1'b0);
        drive_br(3'b010, 1'b1, 1'b1, 1'b1, 32'h0000_0310, 32'h0000_0600, 1'b0, 1'b0);
        drive_br(3'b011, 1'b1, 1'b0, 1'b0, 32'h0000_0314, 32'h0000_0700, 1'b0, 1'b0);
        drive_br(3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 1'b0);

        // Non-branch and invalid cycles must not change anything.
        ex_valid = 1'b1; ex_is_branch = 1'b0; ex_funct3 = 3'b000;
        ex_BrEq = 1'b1; ex_pred_taken = 1'b0; ex_pc = 32'h0000_0900;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_branch = 1'b1;
        @(posedge clk); #1;
        idle();
        check_cnt();

        // Fill the queue with the predictor stalled, then release.
        repeat (3) idle();
        upd_if.upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_br(3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_1000 + 32'(4 * i), 32'h0000_1800, 1'b1, 1'b0);
        end
        drive_br(3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_1010, 32'h0000_1800, 1'b1, 1'b0);
        drive_br(3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_1010, 32'h0000_1800, 1'b1, 1'b1);
        drive_br(3'b001, 1'b1, 1'b0, 1'b0, 32'h0000_1014, 32'h0000_1900, 1'b0, 1'b0);
        ex_valid = 1'b0; ex_is_branch = 1'b0;
        upd_if.upd_ready = 1'b0;
        repeat (2) idle();
        upd_if.upd_ready = 1'b1;
        repeat (6) idle();
        check_cnt();

        // Counter wrap: preload all-ones, one more mispredict.
        force dut.mispred_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispred_cnt_q;
        exp_mp = 32'hFFFF_FFFF;
        check32("mispred_preload", mispred_cnt, 32'hFFFF_FFFF);
        drive_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_3100, 1'b1, 1'b0);
        check32("mispred_wrap", mispred_cnt, 32'h0);
        check_cnt();

        // Reset with three queued updates and a mispredict in flight.
        repeat (3) idle();
        upd_if.upd_ready = 1'b0;
        drive_br(3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_2100, 1'b1, 1'b0);
        drive_br(3'b001, 1'b1, 1'b0, 1'b0, 32'h0000_2004, 32'h0000_2100, 1'b0, 1'b0);
        drive_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_2008, 32'h0000_2100, 1'b1, 1'b0);
        rst = 1'b1;
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'b000;
        ex_BrEq = 1'b1; ex_BrLT = 1'b0; ex_pred_taken = 1'b0;
        ex_pc = 32'h0000_2010; ex_target = 32'h0000_2200;
        @(posedge clk); #1;
        rst = 1'b0;
        ex_valid = 1'b0; ex_is_branch = 1'b0;
        exp_upd.delete();
        exp_br = '0;
        exp_mp = '0;
        check1("rst2_redirect_valid", redirect_valid, 1'b0);
        check32("rst2_redirect_pc", redirect_pc, 32'h0);
        check1("rst2_upd_valid", upd_if.upd_valid, 1'b0);
        check_cnt();
        idle();
        check1("rst2_no_late_redirect", redirect_valid, 1'b0);

        // Normal operation resumes after reset.
        upd_if.upd_ready = 1'b1;
        drive_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0000_4400, 1'b1, 1'b0);
        check_cnt();

        for (int n = 0; n < 20; n++) begin
            if (exp_upd.size() == 0 && exp_redir.size() == 0) break;
            idle();
        end
        idle();
        check32("upd_left", 32'(exp_upd.size()), 32'h0);
        check32("redirect_left", 32'(exp_redir.size()), 32'h0);
        check1("final_upd_valid", upd_if.upd_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
